cfg_ufm_prog_seq: RTL
=====================

// Module: cfg_ufm_prog_seq
// PURPOSE
//  Hardware sequencer that programs/erases the UFM data register, replacing
//  software bit-banging of drclk/drdin/drshft/program/erase over CSR.
//  Software loads a 16-bit word and issues PROGRAM or ERASE; the block shifts
//  the word MSB-first into the UFM DR, pulses program/erase, tracks ufm_busy
//  with timeouts. Sits between the CSR bus and the UFM DR pins; usable only
//  after the boot-time config read finishes (cfg_done=1).
// PARAMETERS
//  BASE_ADDR      5'h0     CSR base; regs at +0 DATA_HI, +1 DATA_LO, +2 CTRL
//  RISE_MAX       16'd255  max cycles waiting for ufm_busy to rise after pulse
//  FALL_MAX       16'hFFFF max cycles waiting for ufm_busy to fall
// PORTS
//  clk          in   1  system clock (only clock)
//  rst          in   1  synchronous, active-high reset
//  csr_a        in   5  CSR address
//  csr_di       in   8  CSR write data
//  csr_we       in   1  CSR write strobe, one cycle per write
//  csr_do       out  8  CSR read data, combinational from csr_a
//  cfg_done     in   1  boot config read complete; commands ignored while 0
//  ufm_drclk    out  1  UFM DR shift clock
//  ufm_drdin    out  1  UFM DR serial data in
//  ufm_drshft   out  1  UFM DR shift(1)/load(0) select
//  ufm_program  out  1  UFM program request
//  ufm_erase    out  1  UFM sector erase request
//  ufm_busy     in   1  UFM busy flag
//  ufm_drdout   in   1  UFM DR serial out (readback only, to CTRL bit 6)
// BEHAVIOUR
//  Reset/idle outputs: drclk=1 drdin=0 drshft=1 program=0 erase=0;
//   data=16'h0, done=0, err=0, state=IDLE; all registered.
//  CSR: DATA_HI/DATA_LO R/W data[15:8]/[7:0]; writes ignored unless IDLE.
//   CTRL write: b0 PROG, b1 ERASE (start), b4 W1C done, b5 W1C err.
//   CTRL read: {seq_busy, ufm_drdout, err, done, 2'b0, ufm_busy, 1'b0};
//   other addresses read 8'h0.
//  Start accepted only in IDLE with cfg_done=1; else silently dropped.
//   PROG&ERASE both set -> rejected, err<=1, stays IDLE. Start clears done/err.
//  FSM: IDLE -> SHIFT (PROG) | PULSE (ERASE) -> WAIT_FALL -> FIN -> IDLE.
//  SHIFT: entered cycle after CTRL write; 32 cycles, bit k (k=15..0):
//   even cycle drclk=0, drdin=data[k]; odd cycle drclk=1 (rising edge
//   latches). drshft=1 throughout. Then PULSE.
//  PULSE: program (PROG) or erase (ERASE) held 1 until ufm_busy seen 1, then
//   deasserted -> WAIT_FALL. If busy not seen within RISE_MAX cycles:
//   deassert, err<=1, -> IDLE.
//  WAIT_FALL: wait ufm_busy=0 -> FIN; after FALL_MAX cycles err<=1 -> IDLE.
//  FIN: one cycle, done<=1, -> IDLE. Timeout counter 16 bit, cleared on
//   each state entry, saturates (no wrap).
//  seq_busy = (state != IDLE).
//  W1C and same-cycle set: set wins. cfg_done falling mid-op: op completes.
//  rst mid-op: immediate return to idle outputs (program/erase dropped in
//   the same cycle rst is sampled); flash contents then undefined.
// TESTING
//  data=16'hA55A, CTRL<=8'h01 -> drdin at 16 drclk rises =1010010101011010,
//   program high until busy=1; busy low after 100 cyc -> done=1, err=0.
//  CTRL<=8'h02, busy pulses 3..50 -> no drclk activity, erase pulse, done=1.
//  CTRL<=8'h01, busy never rises -> program drops at cycle 32+255, err=1.
//  rst at SHIFT cycle 10 -> next cycle drclk=1 drshft=1 program=0, CTRL=8'h00.
//  CTRL<=8'h03 -> err=1, no outputs toggle; cfg_done=0 + CTRL<=8'h01 -> no-op.
//  DATA_HI write during SHIFT ignored; CTRL<=8'h30 clears done and err.

Source files
------------

// File: rtl/cfg_ufm_prog_seq.sv
// Hardware sequencer that shifts a 16-bit word MSB-first into the UFM data register and pulses program/erase.
// A CSR-started operation lasts 32 shift cycles (PROG only), then the pulse/busy handshake; the CSR side never stalls.
module cfg_ufm_prog_seq #(
    parameter logic [4:0]  BASE_ADDR = 5'h0,
    parameter logic [15:0] RISE_MAX  = 16'd255,
    parameter logic [15:0] FALL_MAX  = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       cfg_done,
    output logic       ufm_drclk,
    output logic       ufm_drdin,
    output logic       ufm_drshft,
    output logic       ufm_program,
    output logic       ufm_erase,
    input  logic       ufm_busy,
    input  logic       ufm_drdout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PULSE,
        S_WAIT_FALL,
        S_FIN
    } state_t;

    state_t      state, state_d;
    logic [15:0] data;
    logic [15:0] cnt, cnt_d, cnt_inc;
    logic        prog_op, prog_d;
    logic        done, done_d;
    logic        err, err_d;
    logic        set_done, set_err;
    logic        drclk_d, drdin_d, program_d, erase_d;

    logic sel_hi, sel_lo, sel_ctrl, ctrl_wr;
    logic start_req, start_bad, start_ok;

    assign sel_hi   = (csr_a == BASE_ADDR);
    assign sel_lo   = (csr_a == BASE_ADDR + 5'd1);
    assign sel_ctrl = (csr_a == BASE_ADDR + 5'd2);
    assign ctrl_wr  = csr_we && sel_ctrl;

    assign start_req = ctrl_wr && (csr_di[0] || csr_di[1]) && (state == S_IDLE) && cfg_done;
    assign start_bad = start_req && csr_di[0] && csr_di[1];
    assign start_ok  = start_req && !start_bad;

    // Saturating: a stuck counter must still trip the timeout compare.
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_comb begin
        state_d  = state;
        prog_d   = prog_op;
        set_done = 1'b0;
        set_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    prog_d  = csr_di[0];
                    state_d = csr_di[0] ? S_SHIFT : S_PULSE;
                end
            end
            S_SHIFT: begin
                if (cnt[4:0] == 5'd31)
                    state_d = S_PULSE;
            end
            S_PULSE: begin
                if (ufm_busy) begin
                    state_d = S_WAIT_FALL;
                end else if (cnt >= RISE_MAX - 16'd1) begin
                    state_d = S_IDLE;
                    set_err = 1'b1;
                end
            end
            S_WAIT_FALL: begin
                if (!ufm_busy) begin
                    state_d = S_FIN;
                end else if (cnt >= FALL_MAX - 16'd1) begin
                    state_d = S_IDLE;
                    set_err = 1'b1;
                end
            end
            S_FIN: begin
                state_d  = S_IDLE;
                set_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = (state_d != state || state_d == S_IDLE) ? 16'd0 : cnt_inc;

        // Pin values are derived from the next state so the flops track the state exactly.
        drclk_d   = 1'b1;
        drdin_d   = 1'b0;
        program_d = 1'b0;
        erase_d   = 1'b0;
        if (state_d == S_SHIFT) begin
            drclk_d = cnt_d[0];
            drdin_d = data[4'd15 - cnt_d[4:1]];
        end
        if (state_d == S_PULSE) begin
            program_d = prog_d;
            erase_d   = !prog_d;
        end

        // Clears first, sets last: a set in the same cycle as a W1C wins.
        done_d = done;
        err_d  = err;
        if (ctrl_wr && csr_di[4]) done_d = 1'b0;
        if (ctrl_wr && csr_di[5]) err_d  = 1'b0;
        if (start_req) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (set_done)             done_d = 1'b1;
        if (set_err || start_bad) err_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            prog_op     <= 1'b0;
            data        <= 16'h0;
            done        <= 1'b0;
            err         <= 1'b0;
            ufm_drclk   <= 1'b1;
            ufm_drdin   <= 1'b0;
            ufm_drshft  <= 1'b1;
            ufm_program <= 1'b0;
            ufm_erase   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            prog_op     <= prog_d;
            done        <= done_d;
            err         <= err_d;
            ufm_drclk   <= drclk_d;
            ufm_drdin   <= drdin_d;
            ufm_drshft  <= 1'b1;
            ufm_program <= program_d;
            ufm_erase   <= erase_d;
            if (state == S_IDLE && csr_we && sel_hi) data[15:8] <= csr_di;
            if (state == S_IDLE && csr_we && sel_lo) data[7:0]  <= csr_di;
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (sel_hi)
            csr_do = data[15:8];
        else if (sel_lo)
            csr_do = data[7:0];
        else if (sel_ctrl)
            csr_do = {(state != S_IDLE), ufm_drdout, err, done, 2'b00, ufm_busy, 1'b0};
    end

endmodule
